// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style PIC board top: ROM word format,
// ICW/OCW bit positions, priority helpers and the 7-segment hex font.
package pic_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_RSVD  = 2'd3
    } rom_op_e;

    typedef struct packed {
        rom_op_e    op;
        logic       a0;
        logic [7:0] d;
    } rom_word_t;

    localparam int ICW1_BIT      = 4;
    localparam int ICW1_AEOI_BIT = 1;
    localparam int OCW_SEL_HI    = 4;
    localparam int OCW_SEL_LO    = 3;
    localparam int OCW3_RR_BIT   = 1;
    localparam int OCW3_RIS_BIT  = 0;

    localparam logic [7:0] EOI_NS = 8'h20;

    // Index of the highest set bit; 0 when the vector is empty (callers check |v).
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pic_if.sv
// Bus between the board top (master: commands, IRQ strobe, INTA edges) and the
// PIC core (slave: read data, vector, IRR/ISR and the INT request).
interface pic_if;
    logic       wr_en;
    logic       rd_en;
    logic       a0;
    logic [7:0] wdata;
    logic       irq_stb;
    logic [7:0] irq;
    logic       inta_fall;
    logic       inta_rise;
    logic [7:0] rdata;
    logic [7:0] vector;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       int_req;

    modport master (
        output wr_en, rd_en, a0, wdata, irq_stb, irq, inta_fall, inta_rise,
        input  rdata, vector, irr, isr, int_req
    );

    modport slave (
        input  wr_en, rd_en, a0, wdata, irq_stb, irq, inta_fall, inta_rise,
        output rdata, vector, irr, isr, int_req
    );
endinterface

// File: rtl/pic8259_core.sv
// 8259-style core: IRR/ISR/IMR, fixed priority (IRQ7 highest), two-pulse INTA
// sequence with optional auto-EOI, and the ICW/OCW command decode.
module pic8259_core
    import pic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    pic_if.slave bus
);

    logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
    logic [7:0] vec_q, vec_d, rdat_q, rdat_d, ack_q, ack_d;
    logic [4:0] base_q, base_d;
    logic       init_q, init_d, aeoi_q, aeoi_d, exp_q, exp_d;
    logic       rd_isr_q, rd_isr_d, tgl_q, tgl_d;
    logic [7:0] irr_v_s, unm_v_s, unm_q_s;
    logic [2:0] win_s;
    logic       icw1_s, int_s;

    // Next-state: strobe merges first so newly strobed bits join INTA arbitration;
    // an ICW1 write suppresses any INTA event in the same cycle.
    always_comb begin
        irr_v_s  = bus.irq_stb ? (irr_q | bus.irq) : irr_q;
        unm_v_s  = irr_v_s & ~imr_q;
        win_s    = prio_idx(unm_v_s);
        icw1_s   = bus.wr_en & ~bus.a0 & bus.wdata[ICW1_BIT];
        irr_d    = irr_v_s;
        isr_d    = isr_q;
        imr_d    = imr_q;
        vec_d    = vec_q;
        ack_d    = ack_q;
        base_d   = base_q;
        init_d   = init_q;
        aeoi_d   = aeoi_q;
        exp_d    = exp_q;
        rd_isr_d = rd_isr_q;
        tgl_d    = tgl_q;
        if (icw1_s) begin
            imr_d    = 8'h00;
            isr_d    = 8'h00;
            ack_d    = 8'h00;
            aeoi_d   = bus.wdata[ICW1_AEOI_BIT];
            rd_isr_d = 1'b0;
            exp_d    = 1'b1;
        end else begin
            if (bus.inta_fall && !tgl_q) begin
                if (|unm_v_s) begin
                    isr_d = isr_q | onehot8(win_s);
                    irr_d = irr_v_s & ~onehot8(win_s);
                    vec_d = {base_q, win_s};
                    ack_d = onehot8(win_s);
                end else begin
                    vec_d = {base_q, 3'd7};
                    ack_d = 8'h00;
                end
            end else if (bus.inta_rise) begin
                tgl_d = ~tgl_q;
                if (tgl_q && aeoi_q) begin
                    isr_d = isr_q & ~ack_q;
                end else begin
                    isr_d = isr_q;
                end
            end else begin
                tgl_d = tgl_q;
            end
            if (bus.wr_en) begin
                if (bus.a0) begin
                    if (exp_q) begin
                        base_d = bus.wdata[7:3];
                        init_d = 1'b1;
                        exp_d  = 1'b0;
                    end else begin
                        imr_d = bus.wdata;
                    end
                end else if (bus.wdata[OCW_SEL_HI:OCW_SEL_LO] == 2'b01) begin
                    if (bus.wdata[OCW3_RR_BIT]) begin
                        rd_isr_d = bus.wdata[OCW3_RIS_BIT];
                    end else begin
                        rd_isr_d = rd_isr_q;
                    end
                end else if ((bus.wdata == EOI_NS) && (|isr_d)) begin
                    isr_d = isr_d & ~onehot8(prio_idx(isr_d));
                end else begin
                    imr_d = imr_q;
                end
            end else begin
                exp_d = exp_q;
            end
        end
        if (bus.rd_en) begin
            if (bus.a0) begin
                rdat_d = imr_q;
            end else if (rd_isr_q) begin
                rdat_d = isr_q;
            end else begin
                rdat_d = irr_q;
            end
        end else begin
            rdat_d = rdat_q;
        end
    end

    // INT: an unmasked request that outranks everything in service.
    always_comb begin
        unm_q_s = irr_q & ~imr_q;
        int_s   = init_q && (|unm_q_s) &&
                  ((isr_q == 8'h00) || (prio_idx(unm_q_s) > prio_idx(isr_q)));
    end

    // Core state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irr_q    <= 8'h00;
            isr_q    <= 8'h00;
            imr_q    <= 8'h00;
            vec_q    <= 8'h00;
            rdat_q   <= 8'h00;
            ack_q    <= 8'h00;
            base_q   <= 5'd0;
            init_q   <= 1'b0;
            aeoi_q   <= 1'b0;
            exp_q    <= 1'b0;
            rd_isr_q <= 1'b0;
            tgl_q    <= 1'b0;
        end else begin
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            vec_q    <= vec_d;
            rdat_q   <= rdat_d;
            ack_q    <= ack_d;
            base_q   <= base_d;
            init_q   <= init_d;
            aeoi_q   <= aeoi_d;
            exp_q    <= exp_d;
            rd_isr_q <= rd_isr_d;
            tgl_q    <= tgl_d;
        end
    end

    assign bus.rdata   = rdat_q;
    assign bus.vector  = vec_q;
    assign bus.irr     = irr_q;
    assign bus.isr     = isr_q;
    assign bus.int_req = int_s;

endmodule

// File: rtl/pic_top.sv
// Basys2 top around pic8259_core: button sync/edge detect, command ROM, 7-seg scan.
// Define PIO_TRACE_EN to drive the debug bus on PIO; otherwise PIO floats.
module pic_top
    import pic_pkg::*;
#(
    parameter int ROM_DEPTH    = 16,
    parameter int REFRESH_BITS = 17
) (
    input  logic        MCLK,
    input  logic [3:0]  btn,
    input  logic [7:0]  sw,
    inout  wire  [15:0] PIO,
    output logic [7:0]  Led,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int              PC_W   = $clog2(ROM_DEPTH);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(ROM_DEPTH - 1);

    logic                    rst_s;
    logic [3:1]              sync1_q, sync2_q, prev_q;
    logic [3:1]              rise_s;
    logic                    inta_rel_s;
    logic [PC_W-1:0]         pc_q;
    logic [REFRESH_BITS-1:0] cnt_q;
    logic [7:0]              led_q;
    logic [6:0]              seg_q;
    logic [3:0]              an_q, an_d;
    logic [3:0]              nib_s;
    logic                    dp_q;
    rom_word_t               rom_s;

    pic_if bus ();

    pic8259_core u_core (
        .clk (MCLK),
        .rst (rst_s),
        .bus (bus.slave)
    );

    assign rst_s = btn[0];

    // Two-flop synchronizer plus one history stage for edge detection.
    always_ff @(posedge MCLK or posedge rst_s) begin
        if (rst_s) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
        end else begin
            sync1_q <= btn[3:1];
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_s     = sync2_q & ~prev_q;
    assign inta_rel_s = ~sync2_q[2] & prev_q[2];

    function automatic rom_word_t rom_fetch(input logic [PC_W-1:0] pc);
        rom_word_t w;
        case (pc)
            PC_W'(0): w = '{OP_WRITE, 1'b0, 8'h12};
            PC_W'(1): w = '{OP_WRITE, 1'b1, 8'h20};
            PC_W'(2): w = '{OP_WRITE, 1'b0, 8'h0B};
            PC_W'(3): w = '{OP_READ,  1'b0, 8'h00};
            PC_W'(4): w = '{OP_WRITE, 1'b0, 8'h0A};
            PC_W'(5): w = '{OP_READ,  1'b0, 8'h00};
            default:  w = '{OP_NOP,   1'b0, 8'h00};
        endcase
        return w;
    endfunction

    assign rom_s         = rom_fetch(pc_q);
    assign bus.wr_en     = rise_s[3] & (rom_s.op == OP_WRITE);
    assign bus.rd_en     = rise_s[3] & (rom_s.op == OP_READ);
    assign bus.a0        = rom_s.a0;
    assign bus.wdata     = rom_s.d;
    assign bus.irq_stb   = rise_s[1];
    assign bus.irq       = sw;
    assign bus.inta_fall = rise_s[2];
    assign bus.inta_rise = inta_rel_s;

    // Program counter: advances per ROM step, parks on the last entry.
    always_ff @(posedge MCLK or posedge rst_s) begin
        if (rst_s) begin
            pc_q <= '0;
        end else if (rise_s[3] && (pc_q != PC_MAX)) begin
            pc_q <= pc_q + PC_W'(1);
        end else begin
            pc_q <= pc_q;
        end
    end

    // Digit select: an[0] shows vector[3:0] up to an[3] showing read[7:4].
    always_comb begin
        case (cnt_q[REFRESH_BITS-1 -: 2])
            2'd0:    begin an_d = 4'b1110; nib_s = bus.vector[3:0]; end
            2'd1:    begin an_d = 4'b1101; nib_s = bus.vector[7:4]; end
            2'd2:    begin an_d = 4'b1011; nib_s = bus.rdata[3:0];  end
            2'd3:    begin an_d = 4'b0111; nib_s = bus.rdata[7:4];  end
            default: begin an_d = 4'b1111; nib_s = 4'h0;            end
        endcase
    end

    // Scan counter and registered board outputs.
    always_ff @(posedge MCLK or posedge rst_s) begin
        if (rst_s) begin
            cnt_q <= '0;
            led_q <= 8'h00;
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + REFRESH_BITS'(1);
            led_q <= bus.irr;
            an_q  <= an_d;
            seg_q <= hex_to_seg(nib_s);
            dp_q  <= ~bus.int_req;
        end
    end

    assign Led = led_q;
    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

`ifdef PIO_TRACE_EN
    assign PIO = {2'b00, 4'(pc_q), ~sync2_q[2], bus.int_req, bus.vector};
`else
    assign PIO = 16'bz;
`endif

endmodule

// File: tb/tb_pic_top.sv
// Bench for pic_top: directed bring-up sequence, then random IRQ/INTA/ROM traffic
// checked against a bit-loop reference model of the PIC.
`timescale 1ns/1ps
module tb_pic_top;

    logic        clk = 1'b0;
    logic [3:0]  btn = 4'b0001;
    logic [7:0]  sw  = 8'h00;
    wire  [15:0] pio;
    logic [7:0]  led;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;

    pic_top dut (
        .MCLK (clk),
        .btn  (btn),
        .sw   (sw),
        .PIO  (pio),
        .Led  (led),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    pic_if probe ();
    assign probe.wr_en     = dut.bus.wr_en;
    assign probe.rd_en     = dut.bus.rd_en;
    assign probe.a0        = dut.bus.a0;
    assign probe.wdata     = dut.bus.wdata;
    assign probe.irq_stb   = dut.bus.irq_stb;
    assign probe.irq       = dut.bus.irq;
    assign probe.inta_fall = dut.bus.inta_fall;
    assign probe.inta_rise = dut.bus.inta_rise;
    assign probe.rdata     = dut.bus.rdata;
    assign probe.vector    = dut.bus.vector;
    assign probe.irr       = dut.bus.irr;
    assign probe.isr       = dut.bus.isr;
    assign probe.int_req   = dut.bus.int_req;

    always #5 clk = ~clk;

    logic [6:0] font [16];
    logic [7:0] m_irr, m_isr, m_imr, m_vec, m_rd;
    logic [4:0] m_base;
    bit         m_init, m_aeoi, m_rdisr, m_tgl, m_exp;
    int         m_ack, m_pc;

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_int();
        int a, s;
        a = top_bit(m_irr & ~m_imr);
        s = top_bit(m_isr);
        return m_init && (a >= 0) && ((s < 0) || (a > s));
    endfunction

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_vec = 8'h00; m_rd = 8'h00;
        m_base = 5'd0; m_init = 1'b0; m_aeoi = 1'b0; m_rdisr = 1'b0; m_tgl = 1'b0;
        m_exp = 1'b0; m_ack = -1; m_pc = 0;
    endtask

    task automatic model_strobe(input logic [7:0] req);
        m_irr = m_irr | req;
    endtask

    // One full INTA pulse (press and release).
    task automatic model_inta();
        int w;
        if (!m_tgl) begin
            w = top_bit(m_irr & ~m_imr);
            if (w >= 0) begin
                m_isr[w] = 1'b1;
                m_irr[w] = 1'b0;
                m_vec    = {m_base, 3'(w)};
                m_ack    = w;
            end else begin
                m_vec = {m_base, 3'd7};
                m_ack = -1;
            end
            m_tgl = 1'b1;
        end else begin
            if (m_aeoi && (m_ack >= 0)) m_isr[m_ack] = 1'b0;
            m_tgl = 1'b0;
        end
    endtask

    // ROM program semantics, one entry per step.
    task automatic model_step();
        case (m_pc)
            0: begin m_imr = 8'h00; m_isr = 8'h00; m_aeoi = 1'b1; m_rdisr = 1'b0; m_exp = 1'b1; end
            1: begin
                if (m_exp) begin m_base = 5'(8'h20 >> 3); m_init = 1'b1; m_exp = 1'b0; end
                else m_imr = 8'h20;
            end
            2: m_rdisr = 1'b1;
            3: m_rd = m_rdisr ? m_isr : m_irr;
            4: m_rdisr = 1'b0;
            5: m_rd = m_rdisr ? m_isr : m_irr;
            default: ;
        endcase
        if (m_pc < 15) m_pc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_led"},    32'(led),          32'(m_irr));
        chk({tag, "_dp"},     32'(dp),           32'(!m_int()));
        chk({tag, "_vector"}, 32'(probe.vector), 32'(m_vec));
        chk({tag, "_isr"},    32'(probe.isr),    32'(m_isr));
        chk({tag, "_read"},   32'(probe.rdata),  32'(m_rd));
        chk({tag, "_seg"},    32'(seg),          32'(font[m_vec[3:0]]));
`ifdef PIO_TRACE_EN
        chk({tag, "_pio"},    32'(pio[7:0]),     32'(m_vec));
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] mask);
        @(negedge clk);
        btn = btn | mask;
        @(negedge clk);
        btn = btn & ~mask;
        tick(6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn = 4'b0001;
        tick(3);
        btn = 4'b0000;
        tick(3);
        model_reset();
    endtask

    initial begin
        font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        tick(3);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_dp",  32'(dp),  32'h1);
        chk("rst_an",  32'(an),  32'hE);
        chk("rst_seg", 32'(seg), 32'h40);
        btn = 4'b0000;
        tick(3);

        repeat (3) begin pulse(4'b1000); model_step(); end
        chk("init_pc",  32'(dut.pc_q),        32'd3);
        chk("init_int", 32'(probe.int_req),   32'd0);
        check_state("init");

        sw = 8'h81;
        pulse(4'b0010); model_strobe(8'h81);
        chk("stb_led", 32'(led), 32'h81);
        chk("stb_dp",  32'(dp),  32'h0);
        sw = 8'h3C;
        tick(8);
        chk("sw_level_ignored", 32'(led), 32'h81);

        pulse(4'b0100); model_inta();
        chk("ack1_vec", 32'(probe.vector), 32'h27);
        chk("ack1_led", 32'(led),          32'h01);
        chk("ack1_an",  32'(an),           32'hE);
        pulse(4'b0100); model_inta();
        check_state("pair1");

        pulse(4'b1000); model_step();
        chk("rd_isr", 32'(probe.rdata), 32'h00);
        pulse(4'b1000); model_step();
        pulse(4'b1000); model_step();
        chk("rd_irr", 32'(probe.rdata), 32'h01);

        pulse(4'b0100); model_inta(); pulse(4'b0100); model_inta();
        chk("pair2_vec", 32'(probe.vector), 32'h20);
        chk("pair2_led", 32'(led),          32'h00);
        chk("pair2_dp",  32'(dp),           32'h1);
        pulse(4'b0100); model_inta(); pulse(4'b0100); model_inta();
        chk("spur_vec", 32'(probe.vector), 32'h27);
        chk("spur_isr", 32'(probe.isr),    32'h00);
        check_state("pair3");

        do_reset();
        sw = 8'hFF;
        pulse(4'b0010); model_strobe(8'hFF);
        chk("noinit_led", 32'(led),           32'hFF);
        chk("noinit_int", 32'(probe.int_req), 32'd0);
        pulse(4'b0100); model_inta();
        chk("mid_tgl_set", 32'(dut.u_core.tgl_q), 32'd1);
        @(negedge clk);
        btn = 4'b0100;
        tick(2);
        btn = 4'b0001;
        tick(3);
        btn = 4'b0000;
        tick(3);
        model_reset();
        chk("mid_tgl_clr", 32'(dut.u_core.tgl_q), 32'd0);
        chk("mid_pc",      32'(dut.pc_q),         32'd0);
        check_state("midrst");

        repeat (3) begin pulse(4'b1000); model_step(); end
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin sw = 8'($urandom); pulse(4'b0010); model_strobe(sw); end
                1: begin pulse(4'b0100); model_inta(); end
                2: begin sw = 8'($urandom); pulse(4'b0110); model_strobe(sw); model_inta(); end
                default: begin pulse(4'b1000); model_step(); end
            endcase
            check_state($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
